jk_excitation_driver: RTL and testbench

Drives the J/K inputs of an external bank of `WIDTH` JK flip-flops so that the bank reaches a requested target value. Each target arrives over a valid/ready handshake. The block then:
- computes per-bit excitation from the bank's current Q,
- applies J/K for exactly one clock,
- waits for settle,
- checks the Q feedback against the target.

It is the producer side of the JK flip-flop interface and sits between a control/sequencer block and a flop bank.

---
 rtl/jk_excitation_driver.sv | 67 ++++++
 tb/tb_jk_excitation_driver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: drives a JK flop bank to a handshaked target and checks Q feedback (JK_TOGGLE_EN selects toggle encoding)
module jk_excitation_driver #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] Q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  input  logic             err_clr
);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, CHECK} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] tgt, j_n, k_n;
  logic acc;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE  ? (acc ? DRIVE : IDLE) :
              state == DRIVE ? WAIT :
              state == WAIT  ? (cnt == CW'(1) ? CHECK : WAIT) : IDLE;
  end
  always_comb begin
    tgt_ready = state == IDLE && !rst;
    acc       = tgt_valid && tgt_ready;
`ifdef JK_TOGGLE_EN
    j_n       = Q_fb ^ tgt_data;
    k_n       = Q_fb ^ tgt_data;
`else
    j_n       = ~Q_fb & tgt_data;
    k_n       = Q_fb & ~tgt_data;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      J        <= '0;
      K        <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_mask <= '0;
      cnt      <= '0;
      tgt      <= '0;
    end else begin
      J    <= acc ? j_n : '0;
      K    <= acc ? k_n : '0;
      done <= state == CHECK;
      cnt  <= state == DRIVE ? CW'(SETTLE) : state == WAIT ? cnt - CW'(1) : cnt;
      if (acc) tgt <= tgt_data;
      if (state == CHECK && Q_fb != tgt) begin
        err      <= 1'b1;
        err_mask <= Q_fb ^ tgt;
      end else if (err_clr) begin
        err      <= 1'b0;
        err_mask <= '0;
      end
    end
  end
endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver: directed bench for jk_excitation_driver with behavioural JK flop banks
module tb_jk_excitation_driver;
  logic clk = 1'b0, rst;
  logic v1, r1, d1n, e1, c1, ld1;
  logic [7:0] t1, q1, j1, k1, m1, lv1, stuck1;
  logic v3, r3, d3n, e3, c3, ld3;
  logic [7:0] t3, q3, j3, k3, m3, lv3;
  int vectors = 0, errs = 0;
`ifdef JK_TOGGLE_EN
  localparam logic [7:0] BJ = 8'h33, BK = 8'h33, MJ = 8'h01, MK = 8'h01;
  localparam logic [7:0] AJ = 8'hA5, AK = 8'hA5, FJ = 8'hFF, FK = 8'hFF;
`else
  localparam logic [7:0] BJ = 8'h30, BK = 8'h03, MJ = 8'h00, MK = 8'h01;
  localparam logic [7:0] AJ = 8'hA5, AK = 8'h00, FJ = 8'h5A, FK = 8'hA5;
`endif
  always #5 clk = ~clk;
  jk_excitation_driver #(.WIDTH(8), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .tgt_valid(v1), .tgt_ready(r1), .tgt_data(t1), .Q_fb(q1),
    .J(j1), .K(k1), .done(d1n), .err(e1), .err_mask(m1), .err_clr(c1)
  );
  jk_excitation_driver #(.WIDTH(8), .SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .tgt_valid(v3), .tgt_ready(r3), .tgt_data(t3), .Q_fb(q3),
    .J(j3), .K(k3), .done(d3n), .err(e3), .err_mask(m3), .err_clr(c3)
  );
  always @(posedge clk) q1 <= ld1 ? lv1 : (((j1 & ~q1) | (~k1 & q1)) | stuck1);
  always @(posedge clk) q3 <= ld3 ? lv3 : ((j3 & ~q3) | (~k3 & q3));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; v1 = 1; t1 = 8'h3C; c1 = 0; ld1 = 1; lv1 = 8'h0F; stuck1 = 8'h00;
    v3 = 1; t3 = 8'hA5; c3 = 0; ld3 = 1; lv3 = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_j", j1, 8'h00);
      chk("rst_k", k1, 8'h00);
      chk("rst_done", {7'd0, d1n}, 8'h00);
      chk("rst_err", {7'd0, e1}, 8'h00);
      chk("rst_ready", {7'd0, r1}, 8'h00);
      chk("rst_ready3", {7'd0, r3}, 8'h00);
    end
    rst = 0; v1 = 0; v3 = 0; ld1 = 0; ld3 = 0;
    #1;
    chk("post_rst_ready", {7'd0, r1}, 8'h01);
    chk("post_rst_mask", m1, 8'h00);
    v1 = 1; t1 = 8'h3C;
    tick();
    chk("basic_drive_j", j1, BJ);
    chk("basic_drive_k", k1, BK);
    chk("basic_drive_ready", {7'd0, r1}, 8'h00);
    v1 = 0; t1 = 8'hFF;
    tick();
    chk("basic_wait_j", j1, 8'h00);
    chk("basic_wait_k", k1, 8'h00);
    tick();
    chk("basic_check_done", {7'd0, d1n}, 8'h00);
    tick();
    chk("basic_done", {7'd0, d1n}, 8'h01);
    chk("basic_err", {7'd0, e1}, 8'h00);
    chk("basic_q", q1, 8'h3C);
    chk("basic_ready", {7'd0, r1}, 8'h01);
    tick();
    chk("basic_done_end", {7'd0, d1n}, 8'h00);
    stuck1 = 8'h01; ld1 = 1; lv1 = 8'h01;
    tick();
    ld1 = 0; v1 = 1; t1 = 8'h00;
    tick();
    chk("mis_drive_j", j1, MJ);
    chk("mis_drive_k", k1, MK);
    v1 = 0;
    tick(); tick(); tick();
    chk("mis_done", {7'd0, d1n}, 8'h01);
    chk("mis_err", {7'd0, e1}, 8'h01);
    chk("mis_mask", m1, 8'h01);
    v1 = 1; t1 = 8'h01;
    tick();
    v1 = 0;
    tick(); tick(); tick();
    chk("pass_done", {7'd0, d1n}, 8'h01);
    chk("pass_err_sticky", {7'd0, e1}, 8'h01);
    chk("pass_mask_kept", m1, 8'h01);
    v1 = 1; t1 = 8'hF0;
    tick();
    v1 = 0;
    tick();
    chk("col_q_after_drive", q1, 8'hF1);
    ld1 = 1; lv1 = 8'hAA;
    tick();
    ld1 = 0; c1 = 1;
    tick();
    chk("col_done", {7'd0, d1n}, 8'h01);
    chk("col_err", {7'd0, e1}, 8'h01);
    chk("col_mask", m1, 8'h5A);
    tick();
    chk("clr_err", {7'd0, e1}, 8'h00);
    chk("clr_mask", m1, 8'h00);
    c1 = 0; stuck1 = 8'h00;
    v3 = 1; t3 = 8'hA5;
    tick();
    chk("b2b_a_j", j3, AJ);
    chk("b2b_a_k", k3, AK);
    chk("b2b_a_ready", {7'd0, r3}, 8'h00);
    t3 = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b_a_busy_ready", {7'd0, r3}, 8'h00);
      chk("b2b_a_busy_j", j3, 8'h00);
      chk("b2b_a_busy_k", k3, 8'h00);
    end
    tick();
    chk("b2b_a_done", {7'd0, d3n}, 8'h01);
    chk("b2b_a_q", q3, 8'hA5);
    chk("b2b_a_idle_ready", {7'd0, r3}, 8'h01);
    tick();
    chk("b2b_b_j", j3, FJ);
    chk("b2b_b_k", k3, FK);
    chk("b2b_b_done_low", {7'd0, d3n}, 8'h00);
    v3 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b_b_busy_ready", {7'd0, r3}, 8'h00);
      chk("b2b_b_busy_j", j3, 8'h00);
    end
    tick();
    chk("b2b_b_done", {7'd0, d3n}, 8'h01);
    chk("b2b_b_q", q3, 8'h5A);
    chk("b2b_err", {7'd0, e3}, 8'h00);
    v3 = 1; t3 = 8'hFF;
    tick();
    v3 = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("abort_ready", {7'd0, r3}, 8'h01);
    chk("abort_j", j3, 8'h00);
    chk("abort_k", k3, 8'h00);
    chk("abort_done", {7'd0, d3n}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", {7'd0, d3n}, 8'h00);
      chk("abort_stays_idle", {7'd0, r3}, 8'h01);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
